uart_rx: RTL and testbench

Serial receive half of the UART core, the counterpart to the transmit path that consumes baud ticks. It synchronises the asynchronous `rx_i` line, detects a start bit, samples each data bit at mid-bit using its own divider, and checks the stop bit. It presents the received byte on a valid/ready holding register toward the AXI-Lite register block, and raises single-cycle frame-error and overrun flags.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchroniser, mid-bit sampling FSM, valid/ready holding register
`timescale 1ns/1ps

module uart_rx #(
   parameter int C_BAUDRATE    = 115_200,
   parameter int C_SYSTEM_FREQ = 50_000_000,
   parameter int C_DATA_BITS   = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   rx_i,
   output logic [C_DATA_BITS-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   frame_error,
   output logic                   overrun
);

   localparam int CLKS_PER_BIT = C_SYSTEM_FREQ / C_BAUDRATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int BW           = $clog2(C_DATA_BITS);

   // Divider reload values are "cycles minus one" because the sample happens when the count reaches zero.
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(C_DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                   state_q, state_d;
   logic                     rx_meta_q, rx_meta_d;
   logic                     rx_s_q, rx_s_d;
   logic                     rx_q, rx_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [C_DATA_BITS-1:0]   shift_q, shift_d;
   logic [C_DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                     rx_valid_q, rx_valid_d;
   logic                     frame_error_q, frame_error_d;
   logic                     overrun_q, overrun_d;

   // Two-flop synchroniser for the asynchronous line, plus one more stage for falling-edge detection.
   always_comb begin
      rx_meta_d = rx_i;
      rx_s_d    = rx_meta_q;
      rx_d      = rx_s_q;
   end

   // Next-state, divider, shift register and holding-register logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q & ~rx_ready;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_q && !rx_s_q) begin
               bit_cnt_d = '0;
               cnt_d     = CNT_HALF;
               state_d   = S_START;
            end
         end

         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_s_q) begin
                  cnt_d   = CNT_FULL;
                  state_d = S_DATA;
               end else begin
                  // Line went back high before mid start bit: treat as noise.
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s_q, shift_q[C_DATA_BITS-1:1]};
               cnt_d   = CNT_FULL;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s_q) begin
                  // Return to IDLE immediately so a start bit right after the stop bit is caught.
                  state_d = S_IDLE;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_BREAK: begin
            // A line held low must return high before another start edge can be recognised.
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         rx_q          <= 1'b1;
         cnt_q         <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rx_meta_q     <= rx_meta_d;
         rx_s_q        <= rx_s_d;
         rx_q          <= rx_d;
         cnt_q         <= cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int CPB  = 10;
   localparam int HALF = 5;
   localparam int DW   = 8;

   logic          Clk      = 1'b0;
   logic          Reset    = 1'b1;
   logic          rx_i     = 1'b1;
   logic          rx_ready = 1'b0;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_error;
   logic          overrun;

   int            checks = 0;
   int            errors = 0;
   int            fe_cnt = 0;
   int            ov_cnt = 0;
   logic [7:0]    got_q[$];

   uart_rx #(
      .C_BAUDRATE   (100_000),
      .C_SYSTEM_FREQ(1_000_000),
      .C_DATA_BITS  (DW)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .rx_i       (rx_i),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_error(frame_error),
      .overrun    (overrun)
   );

   always #5 Clk = ~Clk;

   // Observe flags and accepted bytes mid-cycle.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (frame_error) fe_cnt <= fe_cnt + 1;
         if (overrun) ov_cnt <= ov_cnt + 1;
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
   endtask

   task automatic align();
      @(posedge Clk);
      #1;
   endtask

   // Serial frame: start bit, LSB-first data, one stop bit of the chosen level.
   task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns);
      rx_i = 1'b0;
      #(bit_ns);
      for (int i = 0; i < DW; i++) begin
         rx_i = d[i];
         #(bit_ns);
      end
      rx_i = stop;
      #(bit_ns);
   endtask

   task automatic drain();
      align();
      rx_ready = 1'b1;
      align();
      rx_ready = 1'b0;
   endtask

   initial begin
      int         base;
      int         fe0;
      int         ov0;
      int         first_valid;
      int         k;
      real        bit_ns;
      logic [7:0] b;
      logic [7:0] first_b;
      logic [7:0] exp_q[$];
      real        rates[2];

      // Reset values.
      repeat (3) @(posedge Clk);
      #1;
      check("rst_data", 32'(rx_data), 32'h0);
      check("rst_valid", 32'(rx_valid), 32'h0);
      check("rst_ferr", 32'(frame_error), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      Reset = 1'b0;
      cycles(5);

      // Single frame 0xA5 with latency measured from the line's falling edge.
      align();
      first_valid = 0;
      fork
         send_frame(8'hA5, 1'b1, 100.0);
         begin
            for (int c = 1; c <= 130; c++) begin
               @(posedge Clk);
               @(negedge Clk);
               if (rx_valid && first_valid == 0) first_valid = c;
            end
         end
      join
      check("a5_latency", 32'(first_valid), 32'(2 + HALF + (DW + 1) * CPB + 1));
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_valid_held", 32'(rx_valid), 32'h1);
      base = got_q.size();
      drain();
      check("a5_valid_clr", 32'(rx_valid), 32'h0);
      check("a5_accepted", 32'(got_q.size() - base), 32'h1);
      check("a5_acc_data", 32'(got_q[base]), 32'hA5);

      // Back-to-back frames with the consumer always ready.
      base = got_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx_ready = 1'b1;
      send_frame(8'h00, 1'b1, 100.0);
      send_frame(8'hFF, 1'b1, 100.0);
      cycles(20);
      rx_ready = 1'b0;
      check("b2b_count", 32'(got_q.size() - base), 32'h2);
      check("b2b_first", 32'(got_q[base]), 32'h00);
      check("b2b_second", 32'(got_q[base+1]), 32'hFF);
      check("b2b_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'h0);

      // Overrun: second byte dropped while the first is still held.
      ov0 = ov_cnt;
      send_frame(8'h3C, 1'b1, 100.0);
      send_frame(8'hC3, 1'b1, 100.0);
      cycles(5);
      check("ovr_data", 32'(rx_data), 32'h3C);
      check("ovr_valid", 32'(rx_valid), 32'h1);
      check("ovr_pulses", 32'(ov_cnt - ov0), 32'h1);
      base = got_q.size();
      drain();
      check("ovr_drain", 32'(got_q[base]), 32'h3C);

      // Frame error followed by a held-low break, then a clean frame.
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 100.0);
      #300;
      rx_i = 1'b1;
      cycles(30);
      check("ferr_pulses", 32'(fe_cnt - fe0), 32'h1);
      check("ferr_no_valid", 32'(rx_valid), 32'h0);
      send_frame(8'h12, 1'b1, 100.0);
      cycles(5);
      check("ferr_next_valid", 32'(rx_valid), 32'h1);
      check("ferr_next_data", 32'(rx_data), 32'h12);
      drain();

      // Short glitch on an idle line.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      align();
      rx_i = 1'b0;
      #30;
      rx_i = 1'b1;
      cycles(150);
      check("glitch_valid", 32'(rx_valid), 32'h0);
      check("glitch_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'h0);

      // Reset during bit 4 of a frame, with a byte already held.
      send_frame(8'h81, 1'b1, 100.0);
      cycles(3);
      check("pre_rst_valid", 32'(rx_valid), 32'h1);
      align();
      fork
         send_frame(8'h81, 1'b1, 100.0);
         begin
            #550;
            @(posedge Clk);
            #1;
            Reset = 1'b1;
            @(posedge Clk);
            #1;
            check("mid_rst_data", 32'(rx_data), 32'h0);
            check("mid_rst_valid", 32'(rx_valid), 32'h0);
            check("mid_rst_flags", 32'({frame_error, overrun}), 32'h0);
            Reset = 1'b0;
         end
      join
      // Let any frame picked up from the remainder of the line finish, then empty the holding register.
      cycles(200);
      rx_ready = 1'b1;
      cycles(3);
      rx_ready = 1'b0;
      send_frame(8'h81, 1'b1, 100.0);
      cycles(5);
      check("post_rst_data", 32'(rx_data), 32'h81);
      check("post_rst_valid", 32'(rx_valid), 32'h1);
      drain();

      // Baud-rate mismatch at both tolerance edges.
      rates[0] = 98.0;
      rates[1] = 102.0;
      for (int r = 0; r < 2; r++) begin
         fe0 = fe_cnt;
         send_frame(8'h81, 1'b1, rates[r]);
         cycles(5);
         check($sformatf("rate%0d_data", r), 32'(rx_data), 32'h81);
         check($sformatf("rate%0d_ferr", r), 32'(fe_cnt - fe0), 32'h0);
         drain();
      end

      // Random stream: ready held high, every byte must arrive in order.
      exp_q.delete();
      base = got_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom);
         bit_ns = 98.0 + real'($urandom_range(0, 40)) / 10.0;
         exp_q.push_back(b);
         send_frame(b, 1'b1, bit_ns);
         #($urandom_range(0, 200));
      end
      cycles(20);
      rx_ready = 1'b0;
      check("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int n = 0; n < exp_q.size(); n++) begin
         check($sformatf("rnd_byte%0d", n), 32'(got_q[base+n]), 32'(exp_q[n]));
      end
      check("rnd_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'h0);

      // Random bursts with no consumer: first byte kept, the rest counted as overruns.
      for (int r = 0; r < 3; r++) begin
         k = int'($urandom_range(2, 4));
         ov0 = ov_cnt;
         first_b = 8'h00;
         for (int j = 0; j < k; j++) begin
            b = 8'($urandom);
            if (j == 0) first_b = b;
            send_frame(b, 1'b1, 98.0 + real'($urandom_range(0, 40)) / 10.0);
         end
         cycles(5);
         check($sformatf("burst%0d_data", r), 32'(rx_data), 32'(first_b));
         check($sformatf("burst%0d_ovr", r), 32'(ov_cnt - ov0), 32'(k - 1));
         base = got_q.size();
         drain();
         check($sformatf("burst%0d_drain", r), 32'(got_q[base]), 32'(first_b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
